// File: rtl/addressed_fifo.sv
// addressed_fifo: storage element behind the UART TX/RX buffer addresses.
// Each push/pop strobe from the address decoder moves exactly one word.
// Read data is registered (one-cycle pop latency); occupancy is tracked in a
// dedicated counter, and overflow/underflow are sticky until cleared.
module addressed_fifo #(
   parameter int data_width = 8,
   parameter int depth      = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      write_enable,
   input  logic [data_width-1:0]     write_data,
   input  logic                      read_enable,
   output logic [data_width-1:0]     read_data,
   output logic                      read_valid,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(depth):0]    count,
   output logic                      overflow,
   output logic                      underflow,
   input  logic                      clear_errors
);

   localparam int PTR_W = $clog2(depth);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(depth);

   // Storage array; contents are intentionally not reset.
   logic [data_width-1:0] mem_q [depth];

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [data_width-1:0] read_data_q, read_data_d;
   logic                  read_valid_q, read_valid_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic                  full_w;
   logic                  empty_w;
   logic                  pop_acc;
   logic                  push_acc;
   logic                  ovf_set;
   logic                  udf_set;

   // Status flags and accept decisions, all from the pre-edge occupancy.
   always_comb begin
      full_w   = (count_q == DEPTH_CNT);
      empty_w  = (count_q == '0);
      // A same-cycle push never makes an empty FIFO poppable.
      pop_acc  = read_enable & ~empty_w;
      // When full, a simultaneous accepted pop frees the slot being written.
      push_acc = write_enable & (~full_w | pop_acc);
      ovf_set  = write_enable & full_w & ~pop_acc;
      udf_set  = read_enable & empty_w;
   end

   // Next-state for pointers, occupancy, read port and sticky errors.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      read_data_d  = read_data_q;
      read_valid_d = 1'b0;
      overflow_d   = overflow_q;
      underflow_d  = underflow_q;

      // Pointers are exactly PTR_W bits wide, so depth-1 wraps to 0 for free.
      if (push_acc) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end

      if (pop_acc) begin
         rd_ptr_d     = rd_ptr_q + 1'b1;
         read_data_d  = mem_q[rd_ptr_q];
         read_valid_d = 1'b1;
      end

      case ({push_acc, pop_acc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Set has priority over clear so an error in the clearing cycle is kept.
      if (ovf_set) begin
         overflow_d = 1'b1;
      end else if (clear_errors) begin
         overflow_d = 1'b0;
      end

      if (udf_set) begin
         underflow_d = 1'b1;
      end else if (clear_errors) begin
         underflow_d = 1'b0;
      end
   end

   // Control and read-port registers; synchronous reset overrides everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         read_data_q  <= '0;
         read_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         read_data_q  <= read_data_d;
         read_valid_q <= read_valid_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   // Array write; gated by reset so a push in the reset cycle is discarded.
   always_ff @(posedge clk) begin
      if (!reset && push_acc) begin
         mem_q[wr_ptr_q] <= write_data;
      end
   end

   assign read_data  = read_data_q;
   assign read_valid = read_valid_q;
   assign full       = full_w;
   assign empty      = empty_w;
   assign count      = count_q;
   assign overflow   = overflow_q;
   assign underflow  = underflow_q;

endmodule

// File: doc/addressed_fifo.md
# addressed_fifo

Buffered data store that sits directly downstream of the `addressable_if` address decoder in the buffered UART. It consumes the decoder's gated `write_enable_out` and `read_enable_out` strobes: each strobe pushes or pops exactly one word. The block provides a first-word-fall-through-free FIFO with one-cycle registered read data, occupancy status and sticky error flags. It is the storage element behind the UART TX and RX buffer addresses.

## Interface

Parameters:
- `data_width`, 8, width of each stored word.
- `depth`, 16, number of entries; must be a power of two, ≥ 2.

Ports:
- `clk`  input  1  single clock; all state changes on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `write_enable`  input  1  push strobe; driven by the decoder's `write_enable_out`.
- `write_data`  input  `data_width`  word pushed when `write_enable` is high.
- `read_enable`  input  1  pop strobe; driven by the decoder's `read_enable_out`.
- `read_data`  output  `data_width`  popped word; registered.
- `read_valid`  output  1  high for one cycle when `read_data` carries a newly popped word.
- `full`  output  1  occupancy equals `depth`.
- `empty`  output  1  occupancy equals 0.
- `count`  output  `$clog2(depth)+1`  current occupancy, 0..`depth`.
- `overflow`  output  1  sticky; set by a dropped push.
- `underflow`  output  1  sticky; set by a failed pop.
- `clear_errors`  input  1  clears `overflow` and `underflow`.

## Operation

- Storage: `depth`×`data_width` array, write pointer and read pointer, each `$clog2(depth)` bits.
  - Pointers wrap from `depth-1` to 0 naturally.
  - `count` is held in a separate register; it is not derived from the pointers.
- `full` and `empty` are combinational from `count`.
- Push accepted: `write_enable` and (not `full`, or pop accepted this cycle).
  - Array location [write pointer] takes `write_data`.
  - Write pointer increments.
- Pop accepted: `read_enable` and not `empty`. The pre-edge `count` decides this; a same-cycle push does not make an empty FIFO poppable.
  - `read_data` takes array [read pointer].
  - Read pointer increments.
  - `read_valid` is 1 next cycle.
- Rejected pop: `read_valid` is 0 and `read_data` holds its previous value.
- Count update: +1 for a push alone, −1 for a pop alone, unchanged for both or neither.
- Dropped push (`write_enable` while full, no accepted pop): array and pointers unchanged; `overflow` set.
- Failed pop (`read_enable` while empty): `underflow` set.
- `clear_errors` clears both sticky flags. If an error occurs in the same cycle, set wins for that flag.
- Reset (synchronous; overrides every other input):
  - Pointers, `count`, `overflow`, `underflow`, `read_valid` and `read_data` all go to 0.
  - Array contents are don't-care.
  - Reset mid-operation discards all stored words. The first push after reset lands at entry 0.

## Timing

- Push-to-visible: a word pushed at edge N can be popped by a `read_enable` sampled at edge N+1.
- Pop latency: `read_enable` sampled at edge N produces `read_data`/`read_valid` valid after edge N, for one cycle.
- Status: `count`, `full` and `empty` reflect all pushes and pops up to and including the last edge.
- Strobes are level-sampled every cycle. Holding `write_enable` high for k cycles pushes k words (subject to `full`).
- Full plus simultaneous push and pop: both succeed, `count` stays at `depth`, no overflow.
- Empty plus simultaneous push and pop: push succeeds, pop fails, `count` becomes 1, `underflow` is set.
- Deassertion of `reset` at edge N: the first effective operation is sampled at edge N+1.

## Test plan

- Reset then idle: all outputs 0, `empty`=1, `full`=0, `count`=0 for 5 cycles.
- Push 0x11,0x22,0x33, then 3 pops:
  - `read_data` 0x11,0x22,0x33, each with `read_valid`=1 one cycle after its pop.
  - `count` goes 3→0, `empty`=1.
- Fill and overflow with depth 16:
  - Push 0x00..0x0F → `full`=1, `count`=16.
  - Push 0xAA → `overflow`=1, `count` stays 16.
  - Draining 16 words returns 0x00..0x0F; 0xAA never appears.
- Full, then simultaneous push 0x55 and pop:
  - `read_data`=0x00, `count`=16, `overflow`=0.
  - After draining, the 16th word is 0x55, confirming pointer wrap.
- Empty, then pop with simultaneous push 0x77:
  - `underflow`=1, `read_valid`=0, `count`=1.
  - The next pop returns 0x77.
  - `clear_errors` together with a new failed pop leaves `underflow`=1; `clear_errors` alone then gives 0.
- Push 4 words, assert `reset` for 1 cycle, then push 0x99 and pop: `read_data`=0x99 and `count` returns to 0.
